// File: rtl/oam_dma.sv
// rtl/oam_dma.sv - OAM DMA engine: copies LENGTH bytes from a CPU-selected page into OAM
// Reads are issued in XFER; each returned byte is written to OAM exactly one cycle later.
module oam_dma #(
  parameter logic [15:0] REG_ADDR = 16'hFF46,
  parameter int unsigned LENGTH   = 160
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [15:0] wr_addr,
  input  logic [7:0]  wr_data,
  output logic [7:0]  page_q,
  output logic        busy,
  output logic        bus_rd,
  output logic [15:0] bus_addr,
  input  logic [7:0]  bus_data,
  output logic        oam_we,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    XFER  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  localparam logic [7:0] LAST_IDX = 8'(LENGTH - 1);

  state_e     state_q, state_d;
  logic [7:0] page_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] wa_q, wa_d;
  logic       wr_pend_q, wr_pend_d;
  logic       trigger;
  logic [7:0] src_page;

  always_comb begin
    trigger  = wr_en && (wr_addr == REG_ADDR);
    // Pages E0..FF alias the echo region, so fetch from 0x20 pages lower.
    src_page = (page_q >= 8'hE0) ? (page_q - 8'h20) : page_q;

    state_d   = state_q;
    page_d    = page_q;
    idx_d     = idx_q;
    wr_pend_d = (state_q == XFER) && !trigger;
    wa_d      = ((state_q == XFER) && !trigger) ? idx_q : 8'h00;

    unique case (state_q)
      IDLE: begin
        idx_d = 8'h00;
      end
      START: begin
        state_d = XFER;
        idx_d   = 8'h00;
      end
      XFER: begin
        // Compare before incrementing so LENGTH=256 stops at 255 instead of wrapping.
        if (idx_q == LAST_IDX) begin
          state_d = DRAIN;
        end else begin
          idx_d = idx_q + 8'h01;
        end
      end
      DRAIN: begin
        state_d = IDLE;
        idx_d   = 8'h00;
      end
      default: begin
        state_d = IDLE;
        idx_d   = 8'h00;
      end
    endcase

    if (trigger) begin
      page_d  = wr_data;
      state_d = START;
      idx_d   = 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      page_q    <= 8'h00;
      idx_q     <= 8'h00;
      wa_q      <= 8'h00;
      wr_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      page_q    <= page_d;
      idx_q     <= idx_d;
      wa_q      <= wa_d;
      wr_pend_q <= wr_pend_d;
    end
  end

  always_comb begin
    busy      = (state_q != IDLE);
    bus_rd    = (state_q == XFER);
    bus_addr  = bus_rd ? {src_page, idx_q} : 16'h0000;
    oam_we    = wr_pend_q;
    oam_addr  = wa_q;
    oam_wdata = wr_pend_q ? bus_data : 8'h00;
  end

endmodule
